interrupt_ctrl: RTL and testbench

INTERRUPT_CTRL -- requirements
Module: interrupt_ctrl

---
 rtl/interrupt_ctrl_pkg.sv | 27 ++
 rtl/sync_edge_det.sv | 48 ++++
 rtl/interrupt_ctrl.sv | 139 +++++++++++++
 tb/tb_interrupt_ctrl.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/interrupt_ctrl_pkg.sv
// Shared definitions for the interrupt controller.
// Holds the INTCON bit positions, the request state machine encoding and
// the default interrupt vector address.
package interrupt_ctrl_pkg;

    // INTCON bit positions
    localparam int GIE_BIT    = 7;
    localparam int PEIE_BIT   = 6;
    localparam int TMR0IE_BIT = 5;
    localparam int INTE_BIT   = 4;
    localparam int IOCIE_BIT  = 3;
    localparam int TMR0IF_BIT = 2;
    localparam int INTF_BIT   = 1;
    localparam int IOCIF_BIT  = 0;

    // OPTION_REG bit that selects the INT pin edge (1 = rising)
    localparam int INTEDG_BIT = 6;

    localparam logic [14:0] VECTOR_DEFAULT = 15'h0004;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } irq_state_t;

endpackage

// File: rtl/sync_edge_det.sv
// N-stage synchronizer followed by a selectable-polarity edge detector.
// Ports:
//   clock, reset (async, active-low)
//   din     - asynchronous input
//   rising  - 1: pulse on synchronized 0->1, 0: pulse on synchronized 1->0
//   pulse   - single-cycle combinational pulse, valid in the cycle the
//             synchronized value differs from its previous sample
module sync_edge_det #(
    parameter int STAGES = 2
) (
    input  logic clock,
    input  logic reset,
    input  logic din,
    input  logic rising,
    output logic pulse
);

    logic [STAGES-1:0] sync_reg;
    logic              prev_reg;
    logic              sync_out;

    generate
        for (genvar gi = 0; gi < STAGES; gi++) begin : g_sync
            if (gi == 0) begin : g_first
                always_ff @(posedge clock or negedge reset) begin
                    if (!reset) sync_reg[gi] <= 1'b0;
                    else        sync_reg[gi] <= din;
                end
            end else begin : g_rest
                always_ff @(posedge clock or negedge reset) begin
                    if (!reset) sync_reg[gi] <= 1'b0;
                    else        sync_reg[gi] <= sync_reg[gi-1];
                end
            end
        end
    endgenerate

    assign sync_out = sync_reg[STAGES-1];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) prev_reg <= 1'b0;
        else        prev_reg <= sync_out;
    end

    // Combinational pulse so the consuming flag sets on the very next edge.
    assign pulse = rising ? (sync_out & ~prev_reg) : (~sync_out & prev_reg);

endmodule

// File: rtl/interrupt_ctrl.sv
// Interrupt controller: INTCON register, flag capture, request FSM.
// Ports:
//   clock, reset (async, active-low)
//   tmr0_flag, int_pin, iocbf_any, periph_irq - interrupt sources
//   OPTION_REG_in  - bit 6 selects INT pin edge
//   intcon_we/intcon_wdata/intcon_rdata - CPU access to INTCON
//   irq_ack, retfie - CPU handshake
//   irq_req, vector_addr, wake - outputs to CPU / sleep logic
module interrupt_ctrl
    import interrupt_ctrl_pkg::*;
#(
    parameter logic [14:0] VECTOR      = VECTOR_DEFAULT,
    parameter int          SYNC_STAGES = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        tmr0_flag,
    input  logic        int_pin,
    input  logic        iocbf_any,
    input  logic        periph_irq,
    input  logic [7:0]  OPTION_REG_in,
    input  logic        intcon_we,
    input  logic [7:0]  intcon_wdata,
    output logic [7:0]  intcon_rdata,
    input  logic        irq_ack,
    input  logic        retfie,
    output logic        irq_req,
    output logic [14:0] vector_addr,
    output logic        wake
);

    logic gie_reg, peie_reg, tmr0ie_reg, inte_reg, iocie_reg;
    logic tmr0if_reg, intf_reg, iocif_reg;
    logic gie_next, peie_next, tmr0ie_next, inte_next, iocie_next;
    logic tmr0if_next, intf_next;
    logic tmr0_prev_reg;
    logic wake_reg;
    logic tmr0_rise;
    logic int_edge;
    logic pending;
    irq_state_t state_reg, state_next;

    // Bits not consumed by this block (other OPTION_REG fields, read-only IOCIF)
    logic unused_bits;
    assign unused_bits = ^{OPTION_REG_in[7], OPTION_REG_in[5:0], intcon_wdata[IOCIF_BIT]};

    sync_edge_det #(
        .STAGES (SYNC_STAGES)
    ) u_int_sync (
        .clock  (clock),
        .reset  (reset),
        .din    (int_pin),
        .rising (OPTION_REG_in[INTEDG_BIT]),
        .pulse  (int_edge)
    );

    assign tmr0_rise = tmr0_flag & ~tmr0_prev_reg;

    assign pending = (tmr0ie_reg & tmr0if_reg) | (inte_reg & intf_reg) |
                     (iocie_reg & iocif_reg)   | (peie_reg & periph_irq);

    // Register update: CPU write first, then hardware flag sets (so a set
    // beats a software clear), then RETFIE, then ack forcing GIE low last.
    always_comb begin
        gie_next    = gie_reg;
        peie_next   = peie_reg;
        tmr0ie_next = tmr0ie_reg;
        inte_next   = inte_reg;
        iocie_next  = iocie_reg;
        tmr0if_next = tmr0if_reg;
        intf_next   = intf_reg;
        if (intcon_we) begin
            gie_next    = intcon_wdata[GIE_BIT];
            peie_next   = intcon_wdata[PEIE_BIT];
            tmr0ie_next = intcon_wdata[TMR0IE_BIT];
            inte_next   = intcon_wdata[INTE_BIT];
            iocie_next  = intcon_wdata[IOCIE_BIT];
            tmr0if_next = intcon_wdata[TMR0IF_BIT];
            intf_next   = intcon_wdata[INTF_BIT];
        end
        if (tmr0_rise) tmr0if_next = 1'b1;
        if (int_edge)  intf_next   = 1'b1;
        if (retfie)    gie_next    = 1'b1;
        if (irq_ack)   gie_next    = 1'b0;
    end

    always_comb begin
        state_next = state_reg;
        irq_req    = 1'b0;
        case (state_reg)
            IDLE: begin
                if (gie_reg && pending) state_next = REQ;
            end
            REQ: begin
                irq_req = 1'b1;
                if (irq_ack)                     state_next = SERVICE;
                else if (!gie_next || !pending)  state_next = IDLE;
            end
            SERVICE: begin
                if (retfie) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            gie_reg       <= 1'b0;
            peie_reg      <= 1'b0;
            tmr0ie_reg    <= 1'b0;
            inte_reg      <= 1'b0;
            iocie_reg     <= 1'b0;
            tmr0if_reg    <= 1'b0;
            intf_reg      <= 1'b0;
            iocif_reg     <= 1'b0;
            tmr0_prev_reg <= 1'b0;
            wake_reg      <= 1'b0;
            state_reg     <= IDLE;
        end else begin
            gie_reg       <= gie_next;
            peie_reg      <= peie_next;
            tmr0ie_reg    <= tmr0ie_next;
            inte_reg      <= inte_next;
            iocie_reg     <= iocie_next;
            tmr0if_reg    <= tmr0if_next;
            intf_reg      <= intf_next;
            iocif_reg     <= iocbf_any;
            tmr0_prev_reg <= tmr0_flag;
            wake_reg      <= pending;
            state_reg     <= state_next;
        end
    end

    assign intcon_rdata = {gie_reg, peie_reg, tmr0ie_reg, inte_reg,
                           iocie_reg, tmr0if_reg, intf_reg, iocif_reg};
    assign wake        = wake_reg;
    assign vector_addr = VECTOR;

endmodule

// File: tb/tb_interrupt_ctrl.sv
// Self-checking bench for interrupt_ctrl: a vector table walked one cycle
// per row, followed by hand-written INT-pin edge and reset sequences.
module tb_interrupt_ctrl;

    logic        clock;
    logic        reset;
    logic        tmr0_flag;
    logic        int_pin;
    logic        iocbf_any;
    logic        periph_irq;
    logic [7:0]  OPTION_REG_in;
    logic        intcon_we;
    logic [7:0]  intcon_wdata;
    logic [7:0]  intcon_rdata;
    logic        irq_ack;
    logic        retfie;
    logic        irq_req;
    logic [14:0] vector_addr;
    logic        wake;

    int checks = 0;
    int passes = 0;

    interrupt_ctrl dut (
        .clock         (clock),
        .reset         (reset),
        .tmr0_flag     (tmr0_flag),
        .int_pin       (int_pin),
        .iocbf_any     (iocbf_any),
        .periph_irq    (periph_irq),
        .OPTION_REG_in (OPTION_REG_in),
        .intcon_we     (intcon_we),
        .intcon_wdata  (intcon_wdata),
        .intcon_rdata  (intcon_rdata),
        .irq_ack       (irq_ack),
        .retfie        (retfie),
        .irq_req       (irq_req),
        .vector_addr   (vector_addr),
        .wake          (wake)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic       we;
        logic [7:0] wdata;
        logic       tmr0;
        logic       iocbf;
        logic       periph;
        logic       ack;
        logic       ret;
        logic [7:0] exp_rdata;
        logic       exp_irq;
        logic       exp_wake;
    } vec_t;

    vec_t vecs [20];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) begin
            passes++;
            $display("ok   %s act=%0h", name, act);
        end else begin
            $display("FAIL %s act=%0h exp=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic cpu_write(input logic [7:0] data);
        intcon_we    = 1'b1;
        intcon_wdata = data;
        step();
        intcon_we    = 1'b0;
        intcon_wdata = 8'h00;
    endtask

    initial begin
        // we wdata tmr0 iocbf periph ack ret | rdata irq wake
        vecs[0]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 8'hA0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'hA0, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'hA4, 1'b0, 1'b0};
        vecs[3]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'hA4, 1'b1, 1'b1};
        vecs[4]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h24, 1'b0, 1'b1};
        vecs[5]  = '{1'b1, 8'h20, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h20, 1'b0, 1'b1};
        vecs[6]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h20, 1'b0, 1'b0};
        vecs[7]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'hA0, 1'b0, 1'b0};
        vecs[8]  = '{1'b1, 8'hC0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'hC0, 1'b0, 1'b0};
        vecs[9]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'hC0, 1'b1, 1'b1};
        vecs[10] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h40, 1'b0, 1'b1};
        vecs[11] = '{1'b1, 8'hA0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'hA4, 1'b0, 1'b0};
        vecs[12] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'hA4, 1'b0, 1'b1};
        vecs[13] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'hA4, 1'b1, 1'b1};
        vecs[14] = '{1'b1, 8'h24, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h24, 1'b0, 1'b1};
        vecs[15] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h24, 1'b0, 1'b1};
        vecs[16] = '{1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1};
        vecs[17] = '{1'b1, 8'h08, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h09, 1'b0, 1'b0};
        vecs[18] = '{1'b1, 8'h06, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h06, 1'b0, 1'b1};
        vecs[19] = '{1'b1, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};

        reset         = 1'b0;
        tmr0_flag     = 1'b0;
        int_pin       = 1'b0;
        iocbf_any     = 1'b0;
        periph_irq    = 1'b0;
        OPTION_REG_in = 8'h00;
        intcon_we     = 1'b0;
        intcon_wdata  = 8'h00;
        irq_ack       = 1'b0;
        retfie        = 1'b0;

        step();
        step();
        check("reset_rdata", {24'd0, intcon_rdata}, 32'h00);
        check("reset_irq",   {31'd0, irq_req},      32'h0);
        check("reset_wake",  {31'd0, wake},         32'h0);
        check("vector_addr", {17'd0, vector_addr},  32'h0004);
        @(negedge clock);
        reset = 1'b1;
        step();

        // Table: TMR0 request/ack, hardware-wins write, back-to-back
        // request after RETFIE, GIE cleared in REQ, wake without GIE, IOCIF.
        for (int i = 0; i < 20; i++) begin
            intcon_we    = vecs[i].we;
            intcon_wdata = vecs[i].wdata;
            tmr0_flag    = vecs[i].tmr0;
            iocbf_any    = vecs[i].iocbf;
            periph_irq   = vecs[i].periph;
            irq_ack      = vecs[i].ack;
            retfie       = vecs[i].ret;
            step();
            check($sformatf("row%0d_rdata", i), {24'd0, intcon_rdata}, {24'd0, vecs[i].exp_rdata});
            check($sformatf("row%0d_irq", i),   {31'd0, irq_req},      {31'd0, vecs[i].exp_irq});
            check($sformatf("row%0d_wake", i),  {31'd0, wake},         {31'd0, vecs[i].exp_wake});
        end
        intcon_we    = 1'b0;
        intcon_wdata = 8'h00;
        tmr0_flag    = 1'b0;
        iocbf_any    = 1'b0;
        periph_irq   = 1'b0;
        irq_ack      = 1'b0;
        retfie       = 1'b0;

        // INT pin, falling edge selected: rising edge ignored, falling sets
        // INTF exactly three cycles after the pin moves.
        cpu_write(8'h10);
        check("int_inte_set", {24'd0, intcon_rdata}, 32'h10);
        int_pin = 1'b1;
        for (int k = 0; k < 5; k++) step();
        check("int_rise_ignored", {31'd0, intcon_rdata[1]}, 32'h0);
        int_pin = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            step();
            check($sformatf("int_fall_c%0d", k), {31'd0, intcon_rdata[1]}, {31'd0, (k == 3)});
        end

        // Rising edge selected: the same falling stimulus must not set INTF.
        cpu_write(8'h10);
        check("int_clear", {24'd0, intcon_rdata}, 32'h10);
        int_pin = 1'b1;
        for (int k = 0; k < 5; k++) step();
        check("int_rise_ignored2", {31'd0, intcon_rdata[1]}, 32'h0);
        OPTION_REG_in = 8'h40;
        int_pin = 1'b0;
        for (int k = 0; k < 5; k++) step();
        check("int_fall_ignored", {31'd0, intcon_rdata[1]}, 32'h0);
        int_pin = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            step();
            check($sformatf("int_rise_c%0d", k), {31'd0, intcon_rdata[1]}, {31'd0, (k == 3)});
        end

        // Reset in SERVICE, then no request until GIE written again.
        cpu_write(8'h92);
        check("svc_write", {24'd0, intcon_rdata}, 32'h92);
        check("svc_write_irq", {31'd0, irq_req}, 32'h0);
        step();
        check("svc_req", {31'd0, irq_req}, 32'h1);
        irq_ack = 1'b1;
        step();
        irq_ack = 1'b0;
        check("svc_ack_rdata", {24'd0, intcon_rdata}, 32'h12);
        check("svc_ack_irq", {31'd0, irq_req}, 32'h0);
        int_pin       = 1'b0;
        OPTION_REG_in = 8'h00;
        #2;
        reset = 1'b0;
        #1;
        check("async_rst_rdata", {24'd0, intcon_rdata}, 32'h00);
        check("async_rst_irq",   {31'd0, irq_req},      32'h0);
        check("async_rst_wake",  {31'd0, wake},         32'h0);
        @(negedge clock);
        reset = 1'b1;
        step();
        cpu_write(8'h20);
        tmr0_flag = 1'b1;
        step();
        check("post_rst_flag", {24'd0, intcon_rdata}, 32'h24);
        for (int k = 0; k < 3; k++) begin
            step();
            check($sformatf("post_rst_noreq%0d", k), {31'd0, irq_req}, 32'h0);
        end
        cpu_write(8'hA4);
        check("post_rst_gie", {24'd0, intcon_rdata}, 32'hA4);
        step();
        check("post_rst_req", {31'd0, irq_req}, 32'h1);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
